// File: rtl/shift_reg_siso_4_if.sv
// Serial bit-stream link for the SISO delay line.
// The master drives si and receives so; the delay line is the slave.
interface shift_reg_siso_4_if;
  logic si;
  logic so;

  modport master (output si, input so);
  modport slave  (input si, output so);
endinterface

// File: rtl/shift_reg_siso_4.sv
// Fixed-latency serial-in serial-out bit delay line: each bit on si reappears on so DEPTH clocks later.
// Stage 0 is the input end. so comes straight from the last stage, so there is no combinational path from si.
module shift_reg_siso_4 #(
  parameter int unsigned DEPTH       = 4,
  parameter logic        RESET_VALUE = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  shift_reg_siso_4_if.slave  sio
);

  logic [DEPTH-1:0] q_r;

  // Shift one stage toward the output each clock; reset flushes every in-flight bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_r <= {DEPTH{RESET_VALUE}};
    end else begin
      q_r <= {q_r[DEPTH-2:0], sio.si};
    end
  end

  assign sio.so = q_r[DEPTH-1];

endmodule

// File: tb/tb_shift_reg_siso_4.sv
// Scoreboard bench: the driver queues the hand-computed so expected after each edge,
// and an independent monitor compares it against the DUT just after that edge.
module tb_shift_reg_siso_4;

  typedef struct {
    bit    sel8;
    logic  exp;
    string tag;
  } exp_t;

  logic clk = 1'b0;
  logic reset4;
  logic reset8;

  shift_reg_siso_4_if bus4 ();
  shift_reg_siso_4_if bus8 ();

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  shift_reg_siso_4 dut4 (
    .clk   (clk),
    .reset (reset4),
    .sio   (bus4)
  );

  shift_reg_siso_4 #(
    .DEPTH       (8),
    .RESET_VALUE (1'b1)
  ) dut8 (
    .clk   (clk),
    .reset (reset8),
    .sio   (bus8)
  );

  task automatic step4(input logic r, input logic s, input logic e, input string tag);
    @(negedge clk);
    reset4  = r;
    bus4.si = s;
    sb.push_back('{1'b0, e, tag});
  endtask

  task automatic step8(input logic r, input logic s, input logic e, input string tag);
    @(negedge clk);
    reset8  = r;
    bus8.si = s;
    sb.push_back('{1'b1, e, tag});
  endtask

  // Monitor: one expectation per edge, sampled 1 time unit after the rising edge.
  always @(posedge clk) begin
    exp_t e;
    logic act;
    #1;
    if (sb.size() != 0) begin
      e   = sb.pop_front();
      act = e.sel8 ? bus8.so : bus4.so;
      n_vec++;
      if (act !== e.exp) begin
        n_bad++;
        $display("FAIL %s: so=%b expected %b", e.tag, act, e.exp);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    bit alt [32];
    logic e;

    reset4  = 1'b1;
    bus4.si = 1'b0;
    reset8  = 1'b1;
    bus8.si = 1'b0;

    // Reset state and reset flush
    step4(1'b1, 1'b0, 1'b0, "reset_state");
    step4(1'b0, 1'b1, 1'b0, "fill_0");
    step4(1'b0, 1'b1, 1'b0, "fill_1");
    step4(1'b0, 1'b1, 1'b0, "fill_2");
    step4(1'b0, 1'b1, 1'b1, "fill_3");
    step4(1'b1, 1'b1, 1'b0, "flush_reset");
    step4(1'b0, 1'b0, 1'b0, "flush_hold_0");
    step4(1'b0, 1'b0, 1'b0, "flush_hold_1");
    step4(1'b0, 1'b0, 1'b0, "flush_hold_2");

    // Pattern 1,0,1,1 then zeros
    step4(1'b1, 1'b0, 1'b0, "pat_reset");
    step4(1'b0, 1'b1, 1'b0, "pat_0");
    step4(1'b0, 1'b0, 1'b0, "pat_1");
    step4(1'b0, 1'b1, 1'b0, "pat_2");
    step4(1'b0, 1'b1, 1'b1, "pat_3");
    step4(1'b0, 1'b0, 1'b0, "pat_4");
    step4(1'b0, 1'b0, 1'b1, "pat_5");
    step4(1'b0, 1'b0, 1'b1, "pat_6");
    step4(1'b0, 1'b0, 1'b0, "pat_7");

    // Single pulse
    step4(1'b1, 1'b0, 1'b0, "pulse_reset");
    step4(1'b0, 1'b1, 1'b0, "pulse_0");
    step4(1'b0, 1'b0, 1'b0, "pulse_1");
    step4(1'b0, 1'b0, 1'b0, "pulse_2");
    step4(1'b0, 1'b0, 1'b1, "pulse_3");
    step4(1'b0, 1'b0, 1'b0, "pulse_4");
    step4(1'b0, 1'b0, 1'b0, "pulse_5");

    // Mid-stream reset with ones in flight
    step4(1'b0, 1'b1, 1'b0, "mid_0");
    step4(1'b0, 1'b1, 1'b0, "mid_1");
    step4(1'b0, 1'b1, 1'b0, "mid_2");
    step4(1'b0, 1'b1, 1'b1, "mid_3");
    step4(1'b0, 1'b1, 1'b1, "mid_4");
    step4(1'b1, 1'b1, 1'b0, "mid_reset");
    step4(1'b0, 1'b1, 1'b0, "mid_post_0");
    step4(1'b0, 1'b1, 1'b0, "mid_post_1");
    step4(1'b0, 1'b1, 1'b0, "mid_post_2");
    step4(1'b0, 1'b1, 1'b1, "mid_post_3");

    // Alternating stream: so after edge i equals si sampled at edge i-3
    step4(1'b1, 1'b0, 1'b0, "alt_reset");
    for (int i = 0; i < 32; i++) begin
      alt[i] = (i % 2 == 0);
      e = (i < 3) ? 1'b0 : alt[i-3];
      step4(1'b0, alt[i], e, $sformatf("alt_%0d", i));
    end

    // DEPTH=8, RESET_VALUE=1
    step8(1'b1, 1'b0, 1'b1, "d8_reset_0");
    step8(1'b1, 1'b0, 1'b1, "d8_reset_1");
    for (int i = 1; i <= 9; i++) begin
      e = (i <= 7) ? 1'b1 : 1'b0;
      step8(1'b0, 1'b0, e, $sformatf("d8_post_%0d", i));
    end

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations pending, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
